// File: rtl/mips_dmem_io.sv
// Data-memory responder for the MIPS MEM stage: word RAM plus an I/O page
// holding an LED register and a 32-bit compare-match timer.
module mips_dmem_io #(
    parameter int DEPTH_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] memaddr,
    input  logic [31:0] memwritedata,
    output logic [31:0] memreaddata,
    output logic [7:0]  leds,
    output logic        irq
);
    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    localparam logic [29:0] LED_WORD     = 30'h3FFF_C000;
    localparam logic [29:0] COUNT_WORD   = 30'h3FFF_C001;
    localparam logic [29:0] COMPARE_WORD = 30'h3FFF_C002;
    localparam logic [29:0] CTRL_WORD    = 30'h3FFF_C003;

    logic [31:0]   mem [DEPTH_WORDS];
    logic [AW-1:0] ram_idx;
    logic          ram_hit;
    logic          unused_addr_bits;

    logic [7:0]  leds_reg;
    logic [31:0] count_reg, count_next;
    logic [31:0] compare_reg;
    logic        en_reg, irq_en_reg, reload_reg;
    logic        match_flag_reg, match_flag_next;

    logic wr_led, wr_count, wr_compare, wr_ctrl, match;

    assign ram_idx          = memaddr[AW+1:2];
    assign ram_hit          = (memaddr[31:2] < 30'(DEPTH_WORDS));
    assign unused_addr_bits = ^memaddr[1:0];

    assign wr_led     = memwrite && (memaddr[31:2] == LED_WORD);
    assign wr_count   = memwrite && (memaddr[31:2] == COUNT_WORD);
    assign wr_compare = memwrite && (memaddr[31:2] == COMPARE_WORD);
    assign wr_ctrl    = memwrite && (memaddr[31:2] == CTRL_WORD);

    // Match uses pre-edge en/count/compare, so a CTRL write cannot affect it.
    assign match = en_reg && (count_reg == compare_reg);

    always_ff @(posedge clk) begin
        if (memwrite && ram_hit) begin
            mem[ram_idx] <= memwritedata;
        end
    end

    always_comb begin
        count_next = count_reg;
        if (wr_count) begin
            count_next = memwritedata;
        end else if (match) begin
            count_next = reload_reg ? 32'd0 : count_reg + 32'd1;
        end else if (en_reg) begin
            count_next = count_reg + 32'd1;
        end
    end

    // Set takes priority over write-1-to-clear on the same edge.
    always_comb begin
        match_flag_next = match_flag_reg;
        if (match) begin
            match_flag_next = 1'b1;
        end else if (wr_ctrl && memwritedata[8]) begin
            match_flag_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            leds_reg       <= 8'd0;
            count_reg      <= 32'd0;
            compare_reg    <= 32'hFFFF_FFFF;
            en_reg         <= 1'b0;
            irq_en_reg     <= 1'b0;
            reload_reg     <= 1'b0;
            match_flag_reg <= 1'b0;
        end else begin
            count_reg      <= count_next;
            match_flag_reg <= match_flag_next;
            if (wr_led) begin
                leds_reg <= memwritedata[7:0];
            end
            if (wr_compare) begin
                compare_reg <= memwritedata;
            end
            if (wr_ctrl) begin
                en_reg     <= memwritedata[0];
                irq_en_reg <= memwritedata[1];
                reload_reg <= memwritedata[2];
            end
        end
    end

    always_comb begin
        memreaddata = 32'd0;
        if (ram_hit) begin
            memreaddata = mem[ram_idx];
        end else begin
            case (memaddr[31:2])
                LED_WORD:     memreaddata = {24'd0, leds_reg};
                COUNT_WORD:   memreaddata = count_reg;
                COMPARE_WORD: memreaddata = compare_reg;
                CTRL_WORD:    memreaddata = {23'd0, match_flag_reg, 5'd0,
                                             reload_reg, irq_en_reg, en_reg};
                default:      memreaddata = 32'd0;
            endcase
        end
    end

    assign leds = leds_reg;
    assign irq  = match_flag_reg & irq_en_reg;
endmodule

// File: tb/tb_mips_dmem_io.sv
// Directed bench for mips_dmem_io: expectations queued per step, compared
// against the combinational read port and the leds/irq outputs.
module tb_mips_dmem_io;
    logic        clk;
    logic        reset;
    logic        memwrite;
    logic [31:0] memaddr;
    logic [31:0] memwritedata;
    logic [31:0] memreaddata;
    logic [7:0]  leds;
    logic        irq;

    localparam logic [31:0] A_LED  = 32'hFFFF_0000;
    localparam logic [31:0] A_CNT  = 32'hFFFF_0004;
    localparam logic [31:0] A_CMP  = 32'hFFFF_0008;
    localparam logic [31:0] A_CTRL = 32'hFFFF_000C;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_item_t;

    sb_item_t sb_q[$];
    int checks = 0;
    int errors = 0;

    mips_dmem_io #(.DEPTH_WORDS(64)) dut (
        .clk         (clk),
        .reset       (reset),
        .memwrite    (memwrite),
        .memaddr     (memaddr),
        .memwritedata(memwritedata),
        .memreaddata (memreaddata),
        .leds        (leds),
        .irq         (irq)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    task automatic sb_push(input string tag, input logic [31:0] exp);
        sb_item_t it;
        it.tag = tag;
        it.exp = exp;
        sb_q.push_back(it);
    endtask

    task automatic sb_check(input logic [31:0] obs);
        sb_item_t it;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_underflow: observed %h expected none", obs);
        end else begin
            it = sb_q.pop_front();
            assert (obs === it.exp) else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", it.tag, obs, it.exp);
            end
        end
    endtask

    // Reads are combinational; all steps run in the low clock phase.
    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
        sb_push(tag, exp);
        memwrite = 1'b0;
        memaddr  = a;
        #1;
        sb_check(memreaddata);
        $display("read  %h -> %h (%s)", a, memreaddata, tag);
    endtask

    task automatic chk_leds(input logic [7:0] exp, input string tag);
        sb_push(tag, {24'd0, exp});
        sb_check({24'd0, leds});
        $display("leds  = %h (%s)", leds, tag);
    endtask

    task automatic chk_irq(input logic exp, input string tag);
        sb_push(tag, {31'd0, exp});
        sb_check({31'd0, irq});
        $display("irq   = %0b (%s)", irq, tag);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        memwrite     = 1'b1;
        memaddr      = a;
        memwritedata = d;
        @(negedge clk);
        memwrite = 1'b0;
        $display("write %h <- %h", a, d);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "simulation timed out");
    end

    initial begin
        reset = 1'b0;
        memwrite = 1'b0;
        memaddr = 32'd0;
        memwritedata = 32'd0;
        repeat (3) tick();
        reset = 1'b1;
        tick();

        // Reset values
        rd(A_LED,  32'd0,         "rst_led");
        rd(A_CNT,  32'd0,         "rst_count");
        rd(A_CMP,  32'hFFFF_FFFF, "rst_compare");
        rd(A_CTRL, 32'd0,         "rst_ctrl");
        chk_leds(8'd0, "rst_leds");
        chk_irq(1'b0, "rst_irq");

        // RAM write/readback, bounds and unmapped space
        wr(32'h10, 32'hDEAD_BEEF);
        wr(32'hFC, 32'h1234_5678);
        wr(32'h00, 32'h0A0A_0A0A);
        wr(32'h100, 32'h0000_0BAD);
        wr(32'hFFFF_0010, 32'hFFFF_FFFF);
        rd(32'h10, 32'hDEAD_BEEF, "ram_0x10");
        rd(32'hFC, 32'h1234_5678, "ram_0xfc");
        rd(32'h11, 32'hDEAD_BEEF, "ram_lowbits");
        rd(32'h00, 32'h0A0A_0A0A, "ram_no_alias");
        rd(32'h100, 32'd0, "beyond_ram");
        rd(32'h8000_0000, 32'd0, "unmapped");
        rd(A_LED, 32'd0, "led_unaffected");

        // Read during same-word write sees old data; next cycle sees new
        memwrite = 1'b1;
        memaddr = 32'h10;
        memwritedata = 32'h1111_1111;
        sb_push("ram_rdw_old", 32'hDEAD_BEEF);
        #1;
        sb_check(memreaddata);
        @(negedge clk);
        memwrite = 1'b0;
        rd(32'h10, 32'h1111_1111, "ram_rdw_new");

        // Free-run wrap
        wr(A_CNT, 32'hFFFF_FFFE);
        wr(A_CMP, 32'd5);
        wr(A_CTRL, 32'h1);
        rd(A_CNT, 32'hFFFF_FFFE, "wrap_0"); tick();
        rd(A_CNT, 32'hFFFF_FFFF, "wrap_1"); tick();
        rd(A_CNT, 32'd0, "wrap_2"); tick();
        rd(A_CNT, 32'd1, "wrap_3");
        rd(A_CTRL, 32'h001, "wrap_noflag");
        repeat (4) tick();
        rd(A_CNT, 32'd5, "wrap_at5");
        rd(A_CTRL, 32'h001, "wrap_noflag5");
        tick();
        rd(A_CNT, 32'd6, "wrap_after5");
        rd(A_CTRL, 32'h101, "wrap_flag");
        chk_irq(1'b0, "wrap_irq_masked");

        // COUNT write priority while running
        wr(A_CNT, 32'd100);
        rd(A_CNT, 32'd100, "prio_load");
        tick();
        rd(A_CNT, 32'd101, "prio_inc");

        // Timer with reload
        wr(A_CTRL, 32'h100);
        rd(A_CTRL, 32'h000, "clear_disable");
        wr(A_CNT, 32'd0);
        wr(A_CMP, 32'd4);
        wr(A_CTRL, 32'h7);
        for (int i = 0; i < 5; i++) begin
            rd(A_CNT, 32'(i), "reload_seq");
            if (i < 4) tick();
        end
        rd(A_CTRL, 32'h007, "reload_noflag_at4");
        chk_irq(1'b0, "reload_irq_at4");
        tick();
        rd(A_CNT, 32'd0, "reload_wrap");
        rd(A_CTRL, 32'h107, "reload_flag");
        chk_irq(1'b1, "reload_irq");
        wr(A_CTRL, 32'h107);
        rd(A_CNT, 32'd1, "clear_count");
        rd(A_CTRL, 32'h007, "flag_cleared");
        chk_irq(1'b0, "irq_cleared");
        repeat (3) tick();
        rd(A_CNT, 32'd4, "coincide_pre");
        wr(A_CTRL, 32'h107);
        rd(A_CTRL, 32'h107, "set_wins");
        chk_irq(1'b1, "set_wins_irq");
        rd(A_CNT, 32'd0, "coincide_count");

        // Async reset mid-operation
        wr(A_LED, 32'hFFFF_FFA5);
        chk_leds(8'hA5, "led_write");
        rd(A_LED, 32'h0000_00A5, "led_read");
        chk_irq(1'b1, "pre_reset_irq");
        reset = 1'b0;
        #1;
        chk_leds(8'd0, "async_leds");
        chk_irq(1'b0, "async_irq");
        rd(A_CNT, 32'd0, "async_count");
        reset = 1'b1;
        repeat (3) tick();
        rd(A_CNT, 32'd0, "post_reset_hold");
        rd(A_CTRL, 32'd0, "post_reset_ctrl");
        rd(A_CMP, 32'hFFFF_FFFF, "post_reset_cmp");
        wr(A_CTRL, 32'h1);
        rd(A_CNT, 32'd0, "resume_0");
        tick();
        rd(A_CNT, 32'd1, "resume_1");

        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: observed %0d expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mips_dmem_io.md
# mips_dmem_io

Data-memory responder for the pipelined MIPS core's MEM-stage port. It services `memwrite`/`memaddr`/`memwritedata` and returns `memreaddata` in the same cycle. It backs a word-addressed RAM and a small memory-mapped I/O page: an LED register and a 32-bit timer with compare-match interrupt. The block sits outside `mips`, alongside the instruction memory.

## Interface
- `DEPTH_WORDS`, default 64: RAM size in 32-bit words; must be a power of two, at most 16384.
- `clk`, input, 1: sole clock; all state updates on its rising edge.
- `reset`, input, 1: asynchronous, active-low; clears all I/O registers immediately on assertion.
- `memwrite`, input, 1: write strobe from the core's MEM stage.
- `memaddr`, input, 32: byte address; bits [1:0] are ignored (word access only).
- `memwritedata`, input, 32: store data.
- `memreaddata`, output, 32: load data; combinational from `memaddr` and current state.
- `leds`, output, 8: LED register contents.
- `irq`, output, 1: equals `match_flag & irq_en`; combinational from registers.

## Operation
- **Address decode** uses `memaddr[31:2]`.
  - RAM: `memaddr < DEPTH_WORDS*4`. Index is `memaddr[log2(DEPTH_WORDS)+1:2]`.
  - 0xFFFF_0000 LED: read/write, bits [7:0]; upper bits read 0.
  - 0xFFFF_0004 COUNT: read/write; a write loads the value.
  - 0xFFFF_0008 COMPARE: read/write.
  - 0xFFFF_000C CTRL:
    - bit0 `en`, bit1 `irq_en`, bit2 `reload`: read/write.
    - bit8 `match_flag`: read; write 1 to clear, write 0 has no effect.
    - Other bits read 0.
  - Any other address: reads return 0; writes are ignored and have no side effects.
- **RAM**
  - Write on the rising edge when `memwrite=1` and the address hits RAM.
  - Read is asynchronous. It returns the pre-edge contents when a read and write to the same word occur in the same cycle.
  - RAM contents are not reset.
- **Timer**, evaluated each rising edge:
  - If a COUNT write occurs this cycle, `count <= memwritedata`. This overrides every other count update.
  - Otherwise, if `en=1` and `count==compare`, `count <= reload ? 0 : count+1`.
  - Otherwise, if `en=1`, `count <= count+1` (wraps 0xFFFF_FFFF -> 0).
  - Otherwise `count` holds.
- **Match flag**
  - Set on an edge where `en=1` and `count==compare`, using pre-edge values.
  - A CTRL write with bit8=1 clears it.
  - If set and clear happen on the same edge, set wins.
  - A CTRL write also updates `en`/`irq_en`/`reload` on that edge. The match test on that edge uses the old `en`.
- **Reset**
  - Asynchronous: LED=0, COUNT=0, COMPARE=0xFFFF_FFFF, CTRL=0.
  - Consequently `leds=0` and `irq=0` during and after reset.
  - `memreaddata` reflects the reset register values; the RAM is undefined until written.
  - Reset asserted mid-count aborts counting at once. Counting resumes only after software sets `en`.

## Timing
- Read latency is 0 cycles (combinational). The core samples `memreaddata` in the same MEM cycle.
- Write latency is 1 edge. A load in the cycle immediately after a store to the same address returns the new value.
- There is no handshake and no stall: every access completes in one cycle.
- `irq` rises after the edge that sets `match_flag` (when `irq_en=1`). It falls after the edge on which the write-1-clear commits, or immediately on reset.
- With `reload=1` and COMPARE=N, the period is N+1 cycles: the count sequence is 0..N, then 0.

## Test plan
- **Reset values:** hold `reset=0` for 3 cycles, release, then read 0xFFFF_0000/04/08/0C -> 0, 0, 0xFFFF_FFFF, 0; `leds=0`, `irq=0`.
- **RAM write/readback:** write 0xDEADBEEF to 0x10 and 0x12345678 to 0xFC (DEPTH 64). Read them back -> the same values. Read 0x11 -> 0xDEADBEEF (low address bits ignored). Read unmapped 0x8000_0000 -> 0.
- **Timer with reload:**
  - Write COMPARE=4, then CTRL=0x7.
  - COUNT reads 0,1,2,3,4,0 on successive cycles.
  - `match_flag` and `irq` go to 1 after the edge where count was 4.
  - Write CTRL=0x107 -> flag clears and `irq=0`, unless a match coincides, in which case the flag stays 1.
- **Free-run wrap:** write COUNT=0xFFFF_FFFE, COMPARE=5, CTRL=0x1 -> reads 0xFFFF_FFFE, 0xFFFF_FFFF, 0, 1. No flag is set until count reaches 5; `irq` stays 0 because `irq_en=0`.
- **COUNT write priority:** with `en=1` running, write COUNT=100 -> next read is 100, not 101. The count then increments from 100.
- **Async reset mid-operation:** with the timer running, `leds=0xA5` and `irq=1`, pulse `reset=0` between clock edges -> `leds`, `irq` and COUNT go to 0 before the next edge. COUNT stays 0 after release until `en` is rewritten.
